// File: rtl/m_cycleacc_if.sv
// m_cycleacc_if: register bus between a bus master and the cycle accumulator.
//   STB_I  strobe, held by the master until ACK_O
//   WE_I   write enable
//   ADR_I  word select: 0 mcycle, 1 mcycleh, 2 mtimecmp, 3 mtimecmph
//   DAT_I  write data
//   DAT_O  read data, valid while ACK_O=1, zero otherwise
//   ACK_O  one-cycle acknowledge pulse per access
interface m_cycleacc_if;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/m_cycleacc.sv
// m_cycleacc: 64-bit machine cycle accumulator with mtimecmp timer compare.
//   Each opcode fetch presents the cycle count of the previous instruction
//   (incr, 0..63) which is added into mcycle while the core runs.
// Parameters:
//   SPLITCARRY  1: low-word carry reaches the high word one cycle later
//               0: single-cycle 64-bit add
//   CMP_EN      1: mtimecmp and mtip implemented; 0: mtimecmp reads 0, mtip=0
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   corerunning   accumulation enable
//   incr_valid    one-cycle pulse: incr is valid
//   incr          cycles to add
//   bus           register bus (slave side)
//   mtip          registered timer interrupt pending
module m_cycleacc #(
  parameter bit SPLITCARRY = 1'b1,
  parameter bit CMP_EN     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         corerunning,
  input  logic         incr_valid,
  input  logic [5:0]   incr,
  m_cycleacc_if.slave  bus,
  output logic         mtip
);

  logic [31:0] lo_reg, lo_next;
  logic [31:0] hi_reg, hi_next;
  logic        carry_pend_reg, carry_pend_next;
  logic [31:0] hi_shadow_reg;
  logic        ack_reg;
  logic [31:0] dat_reg;
  logic        mtip_reg;
  logic [63:0] cmp_word;

  logic        acc;
  logic        bus_act;
  logic        bus_wr;
  logic        bus_rd;
  logic        wr_lo;
  logic        wr_hi;
  logic [32:0] lo_sum;
  logic        carry_new;
  logic [31:0] rd_mux;

  assign acc     = incr_valid & corerunning;
  // A new access is taken only when no acknowledge is outstanding, which
  // yields exactly one ACK_O pulse per strobe and two cycles per access.
  assign bus_act = bus.STB_I & ~ack_reg;
  assign bus_wr  = bus_act & bus.WE_I;
  assign bus_rd  = bus_act & ~bus.WE_I;
  assign wr_lo   = bus_wr & (bus.ADR_I == 2'd0);
  assign wr_hi   = bus_wr & (bus.ADR_I == 2'd1);

  assign lo_sum    = {1'b0, lo_reg} + {27'd0, incr};
  // A low-word write discards the same-cycle increment and therefore its carry.
  assign carry_new = acc & ~wr_lo & lo_sum[32];

  always_comb begin
    lo_next         = lo_reg;
    hi_next         = hi_reg;
    carry_pend_next = 1'b0;

    if (wr_lo) begin
      lo_next = bus.DAT_I;
    end else if (acc) begin
      lo_next = lo_sum[31:0];
    end

    if (wr_hi) begin
      // Written high word replaces both the pending and the same-cycle carry.
      hi_next = bus.DAT_I;
    end else if (SPLITCARRY) begin
      // A carry already pending belongs to the committed high word, so it is
      // applied even in a cycle where the low word is written.
      hi_next         = hi_reg + {31'd0, carry_pend_reg};
      carry_pend_next = carry_new;
    end else begin
      hi_next = hi_reg + {31'd0, carry_new};
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.ADR_I)
      2'd0: rd_mux = lo_reg;
      2'd1: rd_mux = hi_shadow_reg;
      2'd2: rd_mux = cmp_word[31:0];
      2'd3: rd_mux = cmp_word[63:32];
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_reg         <= 32'd0;
      hi_reg         <= 32'd0;
      carry_pend_reg <= 1'b0;
      hi_shadow_reg  <= 32'd0;
      ack_reg        <= 1'b0;
      dat_reg        <= 32'd0;
    end else begin
      lo_reg         <= lo_next;
      hi_reg         <= hi_next;
      carry_pend_reg <= carry_pend_next;
      ack_reg        <= bus_act;
      dat_reg        <= bus_rd ? rd_mux : 32'd0;
      // Reading the low word snapshots the committed high word (including a
      // pending carry) so a following high-word read is coherent.
      if (bus_rd && (bus.ADR_I == 2'd0)) begin
        hi_shadow_reg <= hi_reg + {31'd0, carry_pend_reg};
      end
    end
  end

  generate
    if (CMP_EN) begin : g_cmp
      for (genvar gi = 0; gi < 2; gi++) begin : g_half
        localparam logic [1:0] HALF_ADR = 2'(gi + 2);
        logic [31:0] half_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            half_reg <= 32'hFFFF_FFFF;
          end else if (bus_wr && (bus.ADR_I == HALF_ADR)) begin
            half_reg <= bus.DAT_I;
          end
        end

        assign cmp_word[gi*32 +: 32] = half_reg;
      end

      // While a carry is in flight {hi,lo} is not the true count, so the
      // previous decision is held rather than glitching.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mtip_reg <= 1'b0;
        end else if (!carry_pend_reg) begin
          mtip_reg <= ({hi_reg, lo_reg} >= cmp_word);
        end
      end
    end else begin : g_nocmp
      assign cmp_word = 64'd0;
      assign mtip_reg = 1'b0;
    end
  endgenerate

  assign bus.ACK_O = ack_reg;
  assign bus.DAT_O = dat_reg;
  assign mtip      = mtip_reg;

endmodule
